// File: rtl/chess_key_pkg.sv
// Shared key indices and key-FSM state encoding for the board-cursor key conditioner.
package chess_key_pkg;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int NUM_KEYS  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

endpackage

// File: rtl/chess_key_debounce.sv
// One key: 2-flop synchroniser, debounce counter and press/repeat FSM producing a raw move pulse.
//
// state  | meaning
// IDLE   | key released; a stable rising edge emits the first pulse
// DELAY  | key held, waiting REPEAT_DELAY clocks before auto-repeat
// REPEAT | key held, one pulse every REPEAT_PERIOD clocks
module chess_key_debounce
    import chess_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clock,
    input  logic resetApp,
    input  logic pressed_i,
    output logic held_o,
    output logic pulse_o
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    key_state_e    state_q, state_d;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            state_q  <= IDLE;
        end else begin
            sync1_q  <= pressed_i;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            state_q  <= state_d;
        end
    end

    // Counter measures how long sync has disagreed with the accepted level; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = '0;
        if (sync_q != stable_q) begin
            if (dcnt_q == DEB_LAST) begin
                stable_d = sync_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_q) begin
                    pulse_o = 1'b1;
                    state_d = DELAY;
                    rcnt_d  = '0;
                end
            end
            DELAY: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == RD_LAST) begin
                        pulse_o = 1'b1;
                        state_d = REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (rcnt_q == RP_LAST) begin
                    pulse_o = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign held_o = stable_q;

endmodule

// File: rtl/chess_key_conditioner.sv
// Four debounced keys feeding a registered priority arbiter (Left > Up > Down > Right).
// resetApp is expected to arrive with its release already synchronised to clock.
module chess_key_conditioner
    import chess_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clock,
    input  logic                resetApp,
    input  logic [NUM_KEYS-1:0] KeyRaw,
    output logic                KeyLeft,
    output logic                KeyUp,
    output logic                KeyDown,
    output logic                KeyRight,
    output logic [NUM_KEYS-1:0] KeyHeld,
    output logic                KeyConflict
);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] raw_pulse;
    logic [NUM_KEYS-1:0] move_q, move_d;
    logic                conflict_q, conflict_d;

    assign pressed = KeyRaw ^ {NUM_KEYS{KEY_ACTIVE_LOW}};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        chess_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_EN)
        ) u_key (
            .clock    (clock),
            .resetApp (resetApp),
            .pressed_i(pressed[k]),
            .held_o   (KeyHeld[k]),
            .pulse_o  (raw_pulse[k])
        );
    end

    // Lowest set bit wins since bit 0 (Left) has the highest priority; losers are dropped.
    always_comb begin
        move_d     = raw_pulse & (~raw_pulse + 1'b1);
        conflict_d = (raw_pulse != move_d);
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            move_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            move_q     <= move_d;
            conflict_q <= conflict_d;
        end
    end

    assign KeyLeft     = move_q[KEY_LEFT];
    assign KeyUp       = move_q[KEY_UP];
    assign KeyDown     = move_q[KEY_DOWN];
    assign KeyRight    = move_q[KEY_RIGHT];
    assign KeyConflict = conflict_q;

endmodule

// File: tb/tb_chess_key_conditioner.sv
// Scoreboard bench: predicted move pulses are queued with their due cycle and compared every cycle.
module tb_chess_key_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = 2 + DEB + 1;

    logic       clock = 1'b0;
    logic       resetApp;
    logic [3:0] KeyRaw;

    logic       KeyLeft, KeyUp, KeyDown, KeyRight, KeyConflict;
    logic [3:0] KeyHeld;
    logic       nr_left, nr_up, nr_down, nr_right, nr_conflict;
    logic [3:0] nr_held;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int nr_cnt = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         due;
        logic [3:0] mv;
        logic       cf;
    } exp_t;
    exp_t sb[$];

    chess_key_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(1'b1), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .resetApp(resetApp), .KeyRaw(KeyRaw),
        .KeyLeft(KeyLeft), .KeyUp(KeyUp), .KeyDown(KeyDown), .KeyRight(KeyRight),
        .KeyHeld(KeyHeld), .KeyConflict(KeyConflict)
    );

    chess_key_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(1'b0), .KEY_ACTIVE_LOW(1'b1)
    ) dut_nr (
        .clock(clock), .resetApp(resetApp), .KeyRaw(KeyRaw),
        .KeyLeft(nr_left), .KeyUp(nr_up), .KeyDown(nr_down), .KeyRight(nr_right),
        .KeyHeld(nr_held), .KeyConflict(nr_conflict)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (nr_down) nr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int due, input logic [3:0] mv, input logic cf);
        exp_t e;
        e.due = due;
        e.mv  = mv;
        e.cf  = cf;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            logic [3:0] exp_mv;
            logic       exp_cf;
            exp_mv = 4'b0;
            exp_cf = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_mv = sb[0].mv;
                exp_cf = sb[0].cf;
                void'(sb.pop_front());
            end
            chk("moves", {KeyRight, KeyDown, KeyUp, KeyLeft}, exp_mv);
            chk("conflict", KeyConflict, exp_cf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int r;
        resetApp = 1'b1;
        KeyRaw   = 4'hF;
        step(3);
        chk("reset_held", KeyHeld, 4'b0000);
        chk("reset_moves", {KeyRight, KeyDown, KeyUp, KeyLeft}, 4'b0000);
        chk("reset_conflict", KeyConflict, 1'b0);
        resetApp = 1'b0;
        mon_en   = 1'b1;
        step(10);

        // clean press of Left, no pulse on release
        KeyRaw[0] = 1'b0;
        e = cyc;
        push(e + LAT, 4'b0001, 1'b0);
        step(10);
        chk("clean_held", KeyHeld, 4'b0001);
        KeyRaw[0] = 1'b1;
        step(12);
        chk("clean_release_held", KeyHeld, 4'b0000);

        // bouncing Up, accepted only after the final edge
        for (int i = 0; i < 6; i++) begin
            KeyRaw[1] = ~KeyRaw[1];
            step(2);
        end
        KeyRaw[1] = 1'b0;
        e = cyc;
        push(e + LAT, 4'b0010, 1'b0);
        step(12);
        KeyRaw[1] = 1'b1;
        step(12);

        // hold Down for repeat; stable drops 6 clocks after release, suppressing the next due pulse
        KeyRaw[2] = 1'b0;
        e = cyc;
        nr_cnt = 0;
        push(e + LAT, 4'b0100, 1'b0);
        for (int t = e + LAT + RD; t < e + 60 + LAT; t += RP) push(t, 4'b0100, 1'b0);
        step(60);
        KeyRaw[2] = 1'b1;
        step(15);
        chk("repeat_off_count", nr_cnt, 1);

        // Left and Right together: Left wins, conflict flagged
        KeyRaw = 4'b0110;
        e = cyc;
        push(e + LAT, 4'b0001, 1'b1);
        step(10);
        chk("collide_held", KeyHeld, 4'b1001);
        KeyRaw = 4'hF;
        step(12);

        // 3-clock glitch on Up is rejected
        KeyRaw[1] = 1'b0;
        step(3);
        KeyRaw[1] = 1'b1;
        step(5);
        chk("glitch_held", KeyHeld, 4'b0000);
        step(8);

        // reset while Right is in DELAY
        KeyRaw[3] = 1'b0;
        e = cyc;
        push(e + LAT, 4'b1000, 1'b0);
        step(12);
        chk("pre_reset_held", KeyHeld, 4'b1000);
        #2 resetApp = 1'b1;
        #1;
        chk("async_reset_held", KeyHeld, 4'b0000);
        chk("async_reset_moves", {KeyRight, KeyDown, KeyUp, KeyLeft, KeyConflict}, 5'b00000);
        step(3);
        resetApp = 1'b0;
        r = cyc;
        push(r + LAT, 4'b1000, 1'b0);
        step(15);
        chk("post_reset_held", KeyHeld, 4'b1000);
        KeyRaw[3] = 1'b1;
        step(15);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
